// File: rtl/imem_rom_loadable.sv
// Loadable instruction memory: one-cycle registered fetch plus a byte-serial
// program loader that writes big-endian words from word 0 upward.
// Ports: clk, reset (async, active-low); fetch addr/rd_en -> data/data_valid/oob;
// loader ld_start/ld_len/ld_byte/ld_byte_valid -> ld_busy/ld_done/ld_count.
module imem_rom_loadable #(
  parameter int    DEPTH     = 256,
  parameter int    ADDR_W    = 31,
  parameter string INIT_FILE = "",
  localparam int   PW        = $clog2(DEPTH),
  localparam int   LW        = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd_en,
  output logic [31:0]       data,
  output logic              data_valid,
  output logic              oob,
  input  logic              ld_start,
  input  logic [LW-1:0]     ld_len,
  input  logic [7:0]        ld_byte,
  input  logic              ld_byte_valid,
  output logic              ld_busy,
  output logic              ld_done,
  output logic [LW-1:0]     ld_count
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t            state;
  logic [31:0]       mem [DEPTH];
  logic [PW-1:0]     ptr;
  logic [1:0]        bcnt;
  logic [23:0]       asm_q;
  logic [LW-1:0]     len_q;
  logic [ADDR_W-3:0] idx;
  logic              idx_oob;
  logic              wr_en;
  logic [31:0]       wr_word;
  logic              last;
  logic              unused_addr;

  assign idx         = addr[ADDR_W-1:2];
  assign idx_oob     = 32'(idx) >= 32'(DEPTH);
  assign unused_addr = ^addr[1:0];

  // Only three bytes are held; the fourth goes straight into the write.
  assign wr_en   = (state == LOAD) && ld_byte_valid && (bcnt == 2'd3);
  assign wr_word = {asm_q, ld_byte};
  assign last    = (ld_count + LW'(1)) == len_q;

  // Power-up image; reset never touches the array.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr] <= wr_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      data       <= '0;
      data_valid <= 1'b0;
      oob        <= 1'b0;
      ld_busy    <= 1'b0;
      ld_done    <= 1'b0;
      ld_count   <= '0;
      bcnt       <= '0;
      ptr        <= '0;
      asm_q      <= '0;
      len_q      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rd_en) begin
            data       <= idx_oob ? '0 : mem[idx[PW-1:0]];
            oob        <= idx_oob;
            data_valid <= 1'b1;
          end
          if (ld_start) begin
            state    <= LOAD;
            ld_busy  <= 1'b1;
            ptr      <= '0;
            bcnt     <= '0;
            ld_count <= '0;
            // Zero or oversize length means fill the whole array.
            if (ld_len == '0 || ld_len > LW'(DEPTH))
              len_q <= LW'(DEPTH);
            else
              len_q <= ld_len;
          end
        end
        LOAD: begin
          data       <= '0;
          oob        <= 1'b0;
          data_valid <= 1'b0;
          if (ld_byte_valid) begin
            asm_q <= {asm_q[15:0], ld_byte};
            bcnt  <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              ld_count <= ld_count + LW'(1);
              if (last) begin
                state   <= DONE;
                ld_busy <= 1'b0;
                ld_done <= 1'b1;
              end else begin
                ptr <= ptr + PW'(1);
              end
            end
          end
        end
        DONE: begin
          data       <= '0;
          oob        <= 1'b0;
          data_valid <= 1'b0;
          ld_done    <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
